// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: memory read bus, instruction valid/ready handshake and redirect port of ifetch_queue; fetch_fault exists only under IFETCH_ALIGN_CHECK_EN
interface ifetch_queue_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif
  modport master (
    output mem_address, mem_read, inst_data, inst_pc, inst_valid,
`ifdef IFETCH_ALIGN_CHECK_EN
    output fetch_fault,
`endif
    input  mem_rdata, mem_resp, inst_ready, redirect, redirect_pc
  );
  modport slave (
    input  mem_address, mem_read, inst_data, inst_pc, inst_valid,
`ifdef IFETCH_ALIGN_CHECK_EN
    input  fetch_fault,
`endif
    output mem_rdata, mem_resp, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: LC-3b fetch stage owning the PC, prefetch FIFO and redirect/drop handling; IFETCH_ALIGN_CHECK_EN adds fetch_fault for odd redirect targets
module ifetch_queue #(
  parameter int          QDEPTH   = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  ifetch_queue_if.master io
);
  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t      st, st_d;
  logic [15:0] pc, pc_d, daddr, daddr_d, tgt;
  logic [15:0] qdata [QDEPTH];
  logic [15:0] qpc [QDEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt, cnt_push;
  logic        push, pop, flush, odd, flt, flt_d;
  assign tgt   = io.redirect_pc & 16'hFFFE;
  assign flt_d = io.redirect ? odd : flt;
  assign pop   = io.inst_valid & io.inst_ready;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign odd = io.redirect_pc[0];
  assign io.fetch_fault = flt;
  // Fault tracks the parity of the most recent redirect target
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flt <= 1'b0;
    else flt <= flt_d;
`else
  assign odd = 1'b0;
  assign flt = 1'b0;
`endif
  // Next state: redirect wins over push/pop; an outstanding read is always completed (DROP) before the new PC is fetched
  always_comb begin
    st_d     = st;
    pc_d     = io.redirect ? tgt : pc;
    daddr_d  = daddr;
    push     = 1'b0;
    flush    = io.redirect;
    cnt_push = cnt + (AW+1)'(1) - (AW+1)'(pop);
    case (st)
      IDLE: st_d = io.redirect ? (flt_d ? IDLE : REQ) : (!flt && cnt < FULL) ? REQ : IDLE;
      REQ: begin
        if (io.redirect) begin
          st_d    = io.mem_resp ? (flt_d ? IDLE : REQ) : DROP;
          daddr_d = pc;
        end else if (io.mem_resp) begin
          push = 1'b1;
          pc_d = pc + 16'd2;
          st_d = cnt_push < FULL ? REQ : IDLE;
        end
      end
      DROP: st_d = io.mem_resp ? (flt_d ? IDLE : REQ) : DROP;
      default: st_d = IDLE;
    endcase
  end
  // Control registers: state, PC and the address held while a stale read drains
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      pc    <= RESET_PC;
      daddr <= RESET_PC;
    end else begin
      st    <= st_d;
      pc    <= pc_d;
      daddr <= daddr_d;
    end
  // Circular buffer; popped and flushed entries are zeroed so an empty queue reads 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qdata[i] <= '0;
        qpc[i]   <= '0;
      end
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qdata[i] <= '0;
        qpc[i]   <= '0;
      end
    end else begin
      if (pop) begin
        qdata[rp] <= '0;
        qpc[rp]   <= '0;
        rp        <= rp + AW'(1);
      end
      if (push) begin
        qdata[wp] <= io.mem_rdata;
        qpc[wp]   <= pc;
        wp        <= wp + AW'(1);
      end
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign io.mem_read    = st != IDLE;
  assign io.mem_address = st == DROP ? daddr : pc;
  assign io.inst_valid  = cnt != '0;
  assign io.inst_data   = qdata[rp];
  assign io.inst_pc     = qpc[rp];
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench; expected fetch stream is the sequential PC run since the last redirect
module tb_ifetch_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  ifetch_queue_if bus();
  ifetch_queue #(.QDEPTH(2), .RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .io(bus.master));
  always #5 clk = ~clk;
  typedef struct packed {logic [15:0] pc; logic [15:0] data;} ent_t;
  ent_t        expq[$];
  ent_t        e;
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] prev_addr = 16'h0000;
  bit          stale = 0, prev_read = 0, prev_resp = 0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  function automatic logic [15:0] rand_tgt();
`ifdef IFETCH_ALIGN_CHECK_EN
    return 16'($urandom) & 16'hFFFE;
`else
    return 16'($urandom);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the reference model, advance to just after the edge
  task automatic cyc(input bit resp, input bit rdy, input bit rd = 1'b0, input logic [15:0] tgt = 16'h0000);
    if (prev_read && !prev_resp) begin
      chk("addr_stable", 32'(bus.mem_address), 32'(prev_addr));
      chk("read_stable", 32'(bus.mem_read), 32'd1);
    end
    bus.mem_resp    = resp && bus.mem_read;
    bus.mem_rdata   = bus.mem_resp ? memf(bus.mem_address) : 16'($urandom);
    bus.inst_ready  = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = tgt;
    if (bus.mem_resp) begin
      if (stale) stale = 0;
      else if (!rd) begin
        chk("fetch_addr", 32'(bus.mem_address), 32'(exp_pc));
        expq.push_back({exp_pc, memf(exp_pc)});
        exp_pc += 16'd2;
      end
    end
    if (rd) begin
      expq.delete();
      exp_pc = tgt & 16'hFFFE;
      if (bus.mem_read && !bus.mem_resp) stale = 1;
    end
    prev_read = bus.mem_read;
    prev_resp = bus.mem_resp;
    prev_addr = bus.mem_address;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = 16'h0000;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    expq.delete();
    exp_pc    = 16'h0000;
    stale     = 0;
    prev_read = 0;
    prev_resp = 0;
  endtask

  // Monitor: a pop happens at the coming edge; compare the head against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.inst_valid && bus.inst_ready && !bus.redirect) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %h data %h, required no valid entry", bus.inst_pc, bus.inst_data);
      end else begin
        e = expq.pop_front();
        chk("pop_pc", 32'(bus.inst_pc), 32'(e.pc));
        chk("pop_data", 32'(bus.inst_data), 32'(e.data));
      end
    end
  end

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_address", 32'(bus.mem_address), 32'h0000);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst_data", 32'(bus.inst_data), 32'h0000);
    chk("rst_inst_pc", 32'(bus.inst_pc), 32'h0000);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_fault", 32'(bus.fetch_fault), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req_read", 32'(bus.mem_read), 32'd1);
    chk("first_req_addr", 32'(bus.mem_address), 32'h0000);
    repeat (3) cyc(0, 0);
    cyc(1, 0);
    chk("t1_valid", 32'(bus.inst_valid), 32'd1);
    chk("t1_pc", 32'(bus.inst_pc), 32'h0000);
    chk("t1_data", 32'(bus.inst_data), 32'h1234);
    chk("t1_next_addr", 32'(bus.mem_address), 32'h0002);
    cyc(1, 0);
    chk("full_read", 32'(bus.mem_read), 32'd0);
    chk("full_addr", 32'(bus.mem_address), 32'h0004);
    repeat (2) cyc(1, 0);
    chk("full_hold_read", 32'(bus.mem_read), 32'd0);
    chk("full_hold_valid", 32'(bus.inst_valid), 32'd1);
    cyc(0, 1);
    cyc(0, 0);
    chk("refill_read", 32'(bus.mem_read), 32'd1);
    chk("refill_addr", 32'(bus.mem_address), 32'h0004);
    cyc(1, 0);
    chk("refill_full_read", 32'(bus.mem_read), 32'd0);
    chk("refill_full_addr", 32'(bus.mem_address), 32'h0006);
    cyc(0, 1);
    cyc(0, 0);
    chk("pre_rst_read", 32'(bus.mem_read), 32'd1);
    chk("pre_rst_valid", 32'(bus.inst_valid), 32'd1);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("async_rst_read", 32'(bus.mem_read), 32'd0);
    chk("async_rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("async_rst_addr", 32'(bus.mem_address), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 0);
    cyc(0, 0, 1, 16'h0400);
    chk("drop_addr", 32'(bus.mem_address), 32'h0002);
    chk("drop_read", 32'(bus.mem_read), 32'd1);
    chk("drop_valid", 32'(bus.inst_valid), 32'd0);
    repeat (2) cyc(0, 0);
    cyc(1, 0);
    chk("drop_done_valid", 32'(bus.inst_valid), 32'd0);
    chk("drop_done_addr", 32'(bus.mem_address), 32'h0400);
    chk("drop_done_read", 32'(bus.mem_read), 32'd1);
    cyc(1, 1);
    cyc(1, 1, 1, 16'h0400);
    chk("redir_resp_valid", 32'(bus.inst_valid), 32'd0);
    chk("redir_resp_data", 32'(bus.inst_data), 32'h0000);
    chk("redir_resp_read", 32'(bus.mem_read), 32'd1);
    chk("redir_resp_addr", 32'(bus.mem_address), 32'h0400);
    cyc(0, 0, 1, 16'hFFFE);
    cyc(1, 0);
    cyc(1, 0);
    chk("wrap_pc0", 32'(bus.inst_pc), 32'hFFFE);
    cyc(1, 0);
    cyc(0, 1);
    chk("wrap_pc1", 32'(bus.inst_pc), 32'h0000);
    cyc(0, 1);
`ifdef IFETCH_ALIGN_CHECK_EN
    cyc(0, 0, 1, 16'h0401);
    cyc(1, 0);
    chk("fault_set", 32'(bus.fetch_fault), 32'd1);
    repeat (3) cyc(1, 0);
    chk("fault_no_fetch", 32'(bus.mem_read), 32'd0);
    cyc(0, 0, 1, 16'h0402);
    chk("fault_clear", 32'(bus.fetch_fault), 32'd0);
    chk("fault_resume_read", 32'(bus.mem_read), 32'd1);
    chk("fault_resume_addr", 32'(bus.mem_address), 32'h0402);
`endif
    repeat (2000)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, rand_tgt());
    repeat (10) cyc(0, 1);
    chk("drain_valid", 32'(bus.inst_valid), 32'd0);
    chk("drain_sb_empty", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
